uart_spbrg: RTL and testbench
=============================

// Module: uart_spbrg
// PURPOSE
//  Baud-rate generator for the PIC16F-style UART (USART SPBRG block). Holds the 8-bit
//  SPBRG register and derives two single-clock strobes from clk: the TX bit-shift enable
//  and the async-RX sampling enable. Sits between the SFR bus and the UART TX/RX engines.
// PARAMETERS
//  none (SPBRG width fixed at 8 bits)
// PORTS
//  clk                     in   1  system clock, all logic on rising edge
//  rst                     in   1  reset, synchronous, active-high
//  sync                    in   1  TXSTA.SYNC: 1 = synchronous mode, 0 = asynchronous
//  brgh                    in   1  TXSTA.BRGH: 1 = high-speed (/16), 0 = low-speed (/64)
//  spbrg_reg_wr_en         in   1  write strobe for SPBRG
//  spbrg_reg_in            in   8  SPBRG write data
//  spbrg_reg_out           out  8  current SPBRG value
//  uart_tx_shift_en        out  1  one-clock TX shift strobe at the baud rate
//  uart_rx_async_div16_en  out  1  one-clock async-RX sampling strobe
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. rst has priority over a write.
//  - State: spbrg (8b); prescaler uart_clk_count (8b, 0..spbrg);
//    uart_clk_count_multiplier m (6b, wraps 63->0); startup counter (2b); two strobe regs.
//  - Reset: spbrg=0, counters=0, both strobes=0, startup counter=2.
//  - Startup: after reset release, the first 2 clock edges only decrement the startup
//    counter; counters and strobes hold (strobes stay 0). Counting begins on the 3rd edge.
//  - Write (wr_en=1, no rst): spbrg<=spbrg_reg_in, uart_clk_count<=0, m<=0, strobes<=0,
//    startup counter<=0. spbrg_reg_out shows the new value the cycle after the write edge.
//  - Counting edge (startup done, no rst/wr):
//    * uart_clk_count != spbrg: uart_clk_count+1; both strobes <= 0.
//    * uart_clk_count == spbrg ("tick"): uart_clk_count<=0; m<=m+1; strobe regs load
//      from the pre-increment m:
//        tx <= sync ? (m[1:0]==3) : brgh ? (m[3:0]==15) : (m==63)
//        rx <= !sync && (m[0]==1)
//  - Outputs are the registered strobes: each pulse is exactly one clock wide.
//  - Resulting periods (clocks, steady state), P = spbrg+1:
//    tx: async brgh=0 64*P, async brgh=1 16*P, sync 4*P; rx (async only): 2*P.
//  - First tx pulse lands exactly one full period after a write edge; after reset release
//    it lands one period + 2 clocks after (startup delay).
//  - Changing brgh/sync mid-count: no restart; m continues and the new compare applies
//    from the next tick (so a 64->16 switch pulses at the next m[3:0]==15).
//  - spbrg=255: prescaler wraps at 255 (P=256). sync=1 forces rx strobe 0.
// TESTING
//  1 Reset held 2 edges then released: outputs all 0, spbrg_reg_out=0; spbrg=0, brgh=0:
//    rx high in cycles after edges 4,6,8..(even), low after odd edges; tx high only after
//    edges 66,130 (low after 65,67).
//  2 Write spbrg=1 (brgh=0): tx low 64 clocks after the write edge, high exactly 128
//    clocks after it; spbrg_reg_out=1.
//  3 Then set brgh=1 right after that tx pulse: tx low at +31, high at +32 clocks.
//  4 Write spbrg=0 with brgh=1: tx high exactly 16 clocks after the write edge, period 16.
//  5 sync=1, spbrg=0: tx pulses every 4 clocks; rx stays 0.
//  6 rst asserted mid-count: next cycle all outputs 0, spbrg_reg_out=0, startup delay reapplies.

Source files
------------

// File: rtl/uart_spbrg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_spbrg
//  Description : USART baud-rate generator. Holds SPBRG and produces one-clock
//                TX shift and async-RX sampling strobes from the system clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_spbrg (
    input  logic       clk,
    input  logic       rst,
    input  logic       sync,
    input  logic       brgh,
    input  logic       spbrg_reg_wr_en,
    input  logic [7:0] spbrg_reg_in,
    output logic [7:0] spbrg_reg_out,
    output logic       uart_tx_shift_en,
    output logic       uart_rx_async_div16_en
);

    localparam logic [1:0] STARTUP_EDGES = 2'd2;

    logic [7:0] spbrg_q;
    logic [7:0] clk_cnt_q, clk_cnt_d;
    logic [5:0] mult_q, mult_d;
    logic [1:0] startup_q, startup_d;
    logic       tx_q, tx_d;
    logic       rx_q, rx_d;
    logic       tx_match;

    // All divisors (4/16/64) divide 64, so one wrapping multiplier serves every mode.
    assign tx_match = sync ? (mult_q[1:0] == 2'b11) :
                      brgh ? (mult_q[3:0] == 4'hF)  :
                             (mult_q == 6'h3F);

    always_comb begin
        clk_cnt_d = clk_cnt_q;
        mult_d    = mult_q;
        startup_d = startup_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        if (startup_q != 2'd0) begin
            startup_d = startup_q - 2'd1;
        end else if (clk_cnt_q != spbrg_q) begin
            clk_cnt_d = clk_cnt_q + 8'd1;
            tx_d      = 1'b0;
            rx_d      = 1'b0;
        end else begin
            clk_cnt_d = 8'd0;
            mult_d    = mult_q + 6'd1;
            tx_d      = tx_match;
            rx_d      = !sync && mult_q[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spbrg_q   <= 8'd0;
            clk_cnt_q <= 8'd0;
            mult_q    <= 6'd0;
            startup_q <= STARTUP_EDGES;
            tx_q      <= 1'b0;
            rx_q      <= 1'b0;
        end else if (spbrg_reg_wr_en) begin
            spbrg_q   <= spbrg_reg_in;
            clk_cnt_q <= 8'd0;
            mult_q    <= 6'd0;
            startup_q <= 2'd0;
            tx_q      <= 1'b0;
            rx_q      <= 1'b0;
        end else begin
            clk_cnt_q <= clk_cnt_d;
            mult_q    <= mult_d;
            startup_q <= startup_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
        end
    end

    assign spbrg_reg_out          = spbrg_q;
    assign uart_tx_shift_en       = tx_q;
    assign uart_rx_async_div16_en = rx_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_spbrg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_spbrg
//  Description : Bench for uart_spbrg: directed scenarios plus random traffic
//                against an arithmetic tick/period model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_spbrg;

    logic       clk;
    logic       rst;
    logic       sync;
    logic       brgh;
    logic       wr_en;
    logic [7:0] din;
    logic [7:0] spbrg_out;
    logic       tx;
    logic       rx;

    int checks   = 0;
    int failures = 0;

    // Reference state: edges counted since counting began, ticks seen since then.
    int         ref_spbrg;
    int         ref_startup;
    int         ref_edges;
    int         ref_ticks;
    logic       ref_tx;
    logic       ref_rx;

    uart_spbrg dut (
        .clk                    (clk),
        .rst                    (rst),
        .sync                   (sync),
        .brgh                   (brgh),
        .spbrg_reg_wr_en        (wr_en),
        .spbrg_reg_in           (din),
        .spbrg_reg_out          (spbrg_out),
        .uart_tx_shift_en       (tx),
        .uart_rx_async_div16_en (rx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int div;
        if (rst) begin
            ref_spbrg = 0; ref_startup = 2; ref_edges = 0; ref_ticks = 0;
            ref_tx = 1'b0; ref_rx = 1'b0;
        end else if (wr_en) begin
            ref_spbrg = int'(din); ref_startup = 0; ref_edges = 0; ref_ticks = 0;
            ref_tx = 1'b0; ref_rx = 1'b0;
        end else if (ref_startup > 0) begin
            ref_startup--;
        end else begin
            ref_edges++;
            if (ref_edges % (ref_spbrg + 1) == 0) begin
                div    = sync ? 4 : (brgh ? 16 : 64);
                ref_tx = (ref_ticks % div) == div - 1;
                ref_rx = !sync && (ref_ticks % 2 == 1);
                ref_ticks++;
            end else begin
                ref_tx = 1'b0;
                ref_rx = 1'b0;
            end
        end
    endtask

    // One clock: edge, update model with the inputs present at that edge, compare.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("tx_model", 32'(tx), 32'(ref_tx));
        check("rx_model", 32'(rx), 32'(ref_rx));
        check("spbrg_model", 32'(spbrg_out), 32'(ref_spbrg));
    endtask

    task automatic write_spbrg(input logic [7:0] v);
        wr_en = 1'b1;
        din   = v;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sync = 1'b0; brgh = 1'b0; wr_en = 1'b0; din = 8'd0;
        ref_spbrg = 0; ref_startup = 2; ref_edges = 0; ref_ticks = 0;
        ref_tx = 1'b0; ref_rx = 1'b0;

        // Reset, release, spbrg=0, /64 async
        step();
        step();
        check("reset_tx", 32'(tx), 32'd0);
        check("reset_rx", 32'(rx), 32'd0);
        check("reset_spbrg", 32'(spbrg_out), 32'd0);
        rst = 1'b0;
        for (int i = 1; i <= 140; i++) begin
            step();
            if (i <= 3) check("startup_tx_low", 32'(tx | rx), 32'd0);
            if (i == 4) check("rx_edge4", 32'(rx), 32'd1);
            if (i == 5) check("rx_edge5", 32'(rx), 32'd0);
            if (i == 65 || i == 67) check("tx_neighbour_low", 32'(tx), 32'd0);
            if (i == 66 || i == 130) check("tx_reset_pulse", 32'(tx), 32'd1);
        end

        // spbrg=1, brgh=0: first tx exactly 128 clocks after the write edge
        write_spbrg(8'd1);
        for (int i = 1; i <= 128; i++) begin
            step();
            if (i == 64) check("wr1_tx_64_low", 32'(tx), 32'd0);
            if (i == 128) check("wr1_tx_128_high", 32'(tx), 32'd1);
        end
        check("wr1_spbrg_out", 32'(spbrg_out), 32'd1);

        // Switch to /16 right after that pulse without restarting the count
        brgh = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            step();
            if (i == 31) check("brgh_tx_31_low", 32'(tx), 32'd0);
            if (i == 32) check("brgh_tx_32_high", 32'(tx), 32'd1);
        end

        // spbrg=0, brgh=1: period 16
        write_spbrg(8'd0);
        for (int i = 1; i <= 48; i++) begin
            step();
            if (i % 16 == 0) check("p16_tx_high", 32'(tx), 32'd1);
            if (i % 16 == 15) check("p16_tx_low", 32'(tx), 32'd0);
        end

        // Synchronous mode: tx every 4 clocks, rx never
        sync = 1'b1;
        write_spbrg(8'd0);
        for (int i = 1; i <= 40; i++) begin
            step();
            check("sync_rx_zero", 32'(rx), 32'd0);
            if (i % 4 == 0) check("sync_tx_high", 32'(tx), 32'd1);
        end

        // Reset mid-count
        sync = 1'b0; brgh = 1'b0;
        write_spbrg(8'd3);
        for (int i = 0; i < 37; i++) step();
        rst = 1'b1;
        step();
        check("midrst_tx", 32'(tx), 32'd0);
        check("midrst_rx", 32'(rx), 32'd0);
        check("midrst_spbrg", 32'(spbrg_out), 32'd0);
        rst = 1'b0;
        for (int i = 1; i <= 70; i++) begin
            step();
            if (i == 65) check("midrst_tx_65_low", 32'(tx), 32'd0);
            if (i == 66) check("midrst_tx_66_high", 32'(tx), 32'd1);
        end

        // Random traffic, including spbrg=255 and mode changes mid-count
        for (int i = 0; i < 6000; i++) begin
            rst   = ($urandom_range(0, 799) == 0);
            wr_en = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 9) == 0) din = 8'd255;
            else                           din = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 199) == 0) brgh = ~brgh;
            if ($urandom_range(0, 399) == 0) sync = ~sync;
            step();
        end
        rst = 1'b0; wr_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
